// File: rtl/lcm_pkg.sv
// Shared types and defaults for the sequential LCM engine.
package lcm_pkg;

  localparam int unsigned LCM_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GCD  = 3'd1,
    ST_DIV  = 3'd2,
    ST_MUL  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/lcm_seq_if.sv
// Operand/result handshake bundle for lcm_seq; master drives operands, slave is the engine.
interface lcm_seq_if #(
  parameter int unsigned WIDTH = lcm_pkg::LCM_WIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   gcd_out;
  logic [2*WIDTH-1:0] lcm_out;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gcd_out, lcm_out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gcd_out, lcm_out, busy
  );
endinterface

// File: rtl/lcm_seq_udiv_iter.sv
// Restoring unsigned divider: loads on start_i, then one quotient bit per edge, MSB first.
module udiv_iter
  import lcm_pkg::*;
#(
  parameter int unsigned WIDTH = LCM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q, quot_q[WIDTH-1]};
    if (start_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      den_d  = divisor_i;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d  = WIDTH'(trial - {1'b0, den_q});
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = trial[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done_o flags the edge that produces the last quotient bit; quot_o is final after it.
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign quot_o = quot_q;

endmodule

// File: rtl/lcm_seq.sv
// Sequential LCM engine: subtractive GCD, then lcm = (a / gcd) * b via iterative divide and shift-add.
module lcm_seq
  import lcm_pkg::*;
#(
  parameter int unsigned WIDTH = LCM_WIDTH
) (
  input logic      clk,
  input logic      rst,
  lcm_seq_if.slave bus
);
  localparam int unsigned MW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d, g_q, g_d;
  logic [WIDTH-1:0]   gcd_q, gcd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, lcm_q, lcm_d;
  logic [MW-1:0]      bit_q, bit_d;
  logic [2*WIDTH-1:0] acc_sum;
  logic               div_start, div_done;
  logic [WIDTH-1:0]   quot;

  // Divider is started on the GCD exit edge with x (== gcd), so DIV spends exactly WIDTH edges.
  udiv_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (a_q),
    .divisor_i  (x_q),
    .done_o     (div_done),
    .quot_o     (quot)
  );

  assign acc_sum = acc_q + (quot[bit_q] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    x_d       = x_q;
    y_d       = y_q;
    g_d       = g_q;
    gcd_d     = gcd_q;
    lcm_d     = lcm_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    bit_d     = bit_q;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        a_d = bus.a;
        b_d = bus.b;
        if ((bus.a == '0) || (bus.b == '0)) begin
          gcd_d   = bus.a | bus.b;
          lcm_d   = '0;
          state_d = ST_DONE;
        end else begin
          x_d     = bus.a;
          y_d     = bus.b;
          state_d = ST_GCD;
        end
      end
      ST_GCD: begin
        if (y_q == '0) begin
          g_d       = x_q;
          div_start = 1'b1;
          state_d   = ST_DIV;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      ST_DIV: if (div_done) begin
        acc_d   = '0;
        mcand_d = {{WIDTH{1'b0}}, b_q};
        bit_d   = '0;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        bit_d   = bit_q + MW'(1);
        if (bit_q == MW'(WIDTH - 1)) begin
          gcd_d   = g_q;
          lcm_d   = acc_sum;
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      g_q     <= '0;
      gcd_q   <= '0;
      lcm_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      g_q     <= g_d;
      gcd_q   <= gcd_d;
      lcm_q   <= lcm_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      bit_q   <= bit_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_GCD) || (state_q == ST_DIV) || (state_q == ST_MUL);
  assign bus.gcd_out   = gcd_q;
  assign bus.lcm_out   = lcm_q;

endmodule

// File: tb/tb_lcm_seq.sv
// Directed and back-to-back checks of lcm_seq against hand-computed gcd/lcm values.
module tb_lcm_seq;
  localparam int unsigned W = lcm_pkg::LCM_WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lcm_seq_if #(.WIDTH(W)) bus ();
  lcm_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one pair, waits (bounded) for out_valid; lat counts edges after the accepting edge.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [W-1:0] g, output logic [2*W-1:0] l, output int lat);
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 1000) begin
      tick();
      lat++;
    end
    g = bus.gcd_out;
    l = bus.lcm_out;
  endtask

  task automatic release_result;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  function automatic int unsigned sw_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++;
    if (bus.gcd_out !== '0 || bus.lcm_out !== '0) begin
      fails++; $display("FAIL reset_results: got gcd=%0d lcm=%0d want 0 0", bus.gcd_out, bus.lcm_out);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] g; logic [2*W-1:0] l; int lat;
    run_op(8'd12, 8'd18, g, l, lat);
    tests++;
    if (g !== 8'd6 || l !== 16'd36) begin fails++; $display("FAIL basic_12_18: got gcd=%0d lcm=%0d want 6 36", g, l); end
    tests++;
    if (lat !== 20) begin fails++; $display("FAIL basic_latency: got %0d want 20", lat); end
    tests++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL basic_done_flags: got busy=%b in_ready=%b want 0 0", bus.busy, bus.in_ready);
    end
    release_result();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL basic_release: got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_large;
    logic [W-1:0] g; logic [2*W-1:0] l; int lat;
    run_op(8'd255, 8'd254, g, l, lat);
    tests++;
    if (bus.out_valid !== 1'b1 || g !== 8'd1 || l !== 16'd64770) begin
      fails++; $display("FAIL large_255_254: got valid=%b gcd=%0d lcm=%0d want 1 1 64770", bus.out_valid, g, l);
    end
    release_result();
    run_op(8'd255, 8'd255, g, l, lat);
    tests++;
    if (g !== 8'd255 || l !== 16'd255) begin fails++; $display("FAIL equal_255: got gcd=%0d lcm=%0d want 255 255", g, l); end
    tests++;
    if (lat !== 18) begin fails++; $display("FAIL equal_latency: got %0d want 18", lat); end
    release_result();
  endtask

  task automatic test_zero;
    logic [W-1:0] g; logic [2*W-1:0] l; int lat;
    run_op(8'd0, 8'd7, g, l, lat);
    tests++;
    if (g !== 8'd7 || l !== 16'd0 || lat !== 0) begin
      fails++; $display("FAIL zero_0_7: got gcd=%0d lcm=%0d lat=%0d want 7 0 0", g, l, lat);
    end
    release_result();
    run_op(8'd0, 8'd0, g, l, lat);
    tests++;
    if (g !== 8'd0 || l !== 16'd0 || lat !== 0) begin
      fails++; $display("FAIL zero_0_0: got gcd=%0d lcm=%0d lat=%0d want 0 0 0", g, l, lat);
    end
    release_result();
  endtask

  task automatic test_stall;
    logic [W-1:0] g; logic [2*W-1:0] l; int lat;
    run_op(8'd12, 8'd18, g, l, lat);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a = W'(i + 1);
      bus.b = 8'd3;
      bus.out_ready = 1'b0;
      tick();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.gcd_out !== 8'd6 || bus.lcm_out !== 16'd36 || bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_cycle%0d: got valid=%b gcd=%0d lcm=%0d in_ready=%b want 1 6 36 0",
                 i, bus.out_valid, bus.gcd_out, bus.lcm_out, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: got valid=%b in_ready=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] g; logic [2*W-1:0] l; int lat;
    bus.a = 8'd255;
    bus.b = 8'd1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL midop_busy: got %b want 1", bus.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.lcm_out !== '0 || bus.gcd_out !== '0) begin
      fails++;
      $display("FAIL midop_reset: got in_ready=%b valid=%b busy=%b gcd=%0d lcm=%0d want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.gcd_out, bus.lcm_out);
    end
    run_op(8'd4, 8'd6, g, l, lat);
    tests++;
    if (g !== 8'd2 || l !== 16'd12 || lat !== 20) begin
      fails++; $display("FAIL after_reset_4_6: got gcd=%0d lcm=%0d lat=%0d want 2 12 20", g, l, lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back;
    int unsigned pa[50];
    int unsigned pb[50];
    int unsigned eg, el;
    int ai, ri, cyc;
    logic acc, rel;
    for (int i = 0; i < 50; i++) begin
      pa[i] = $urandom_range(1, 255);
      pb[i] = $urandom_range(1, 255);
    end
    ai = 0; ri = 0; cyc = 0;
    while (ri < 50 && cyc < 40000) begin
      bus.in_valid = (ai < 50);
      if (ai < 50) begin
        bus.a = W'(pa[ai]);
        bus.b = W'(pb[ai]);
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      acc = bus.in_valid && bus.in_ready;
      rel = bus.out_valid && bus.out_ready;
      if (rel) begin
        eg = sw_gcd(pa[ri], pb[ri]);
        el = (pa[ri] / eg) * pb[ri];
        tests++;
        if (ri >= ai || 32'(bus.gcd_out) !== eg || 32'(bus.lcm_out) !== el) begin
          fails++;
          $display("FAIL b2b_result%0d: got gcd=%0d lcm=%0d want %0d %0d (a=%0d b=%0d)",
                   ri, bus.gcd_out, bus.lcm_out, eg, el, pa[ri], pb[ri]);
        end
        ri++;
      end
      tick();
      cyc++;
      if (acc) ai++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tests++;
    if (ai !== 50 || ri !== 50) begin
      fails++; $display("FAIL b2b_count: got accepted=%0d released=%0d want 50 50", ai, ri);
    end
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_idle: got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_basic();
    test_large();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
